// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable FWFT read port.
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int AFULL_TH  = 56,
   parameter int AEMPTY_TH = 8,
   parameter int FWFT      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int             DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] C_AF_TH = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] C_AE_TH = (ADDR_W+1)'(AEMPTY_TH);

   if (DATA_W < 1 || ADDR_W < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
       AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH || AEMPTY_TH >= AFULL_TH) begin : g_param_err
      $error("sync_fifo_param: illegal threshold/size parameters");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_wr_ptr;
   logic [ADDR_W:0]   r_rd_ptr;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [ADDR_W:0]   w_count;

   // Status is decoded purely from the registered pointers; the MSB is the wrap bit.
   assign w_count  = r_wr_ptr - r_rd_ptr;
   assign w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_wr_acc = wr_en & ~w_full;
   assign w_rd_acc = rd_en & ~w_empty;

   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = w_count;
   assign almost_full  = (w_count >= C_AF_TH);
   assign almost_empty = (w_count <= C_AE_TH);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_ONE;
      end
   end

   // A new error event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && w_full)   r_overflow <= 1'b1;
         else if (clr_err)      r_overflow <= 1'b0;
         if (rd_en && w_empty)  r_underflow <= 1'b1;
         else if (clr_err)      r_underflow <= 1'b0;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is always on the output; a pop simply advances the read pointer.
      assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
      assign rd_valid = ~w_empty;
   end else begin : g_std
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
         end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: one standard-read and one FWFT instance
// share the same stimulus and are checked against a queue-based reference model.
module tb_sync_fifo_param;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          full0, full1, empty0, empty1;
   logic          af0, af1, ae0, ae1;
   logic [AW:0]   count0, count1;
   logic          ovf0, ovf1, udf0, udf1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp0 [$];
   logic [DW-1:0] exp1 [$];
   bit            m_ovf = 0;
   bit            m_udf = 0;
   logic [DW-1:0] last_std = '0;

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(udf0), .clr_err(clr_err));

   sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(udf1), .clr_err(clr_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Standard port: every rd_valid pulse must match the next word the model popped.
   always @(negedge clk) begin
      if (!rst && rd_valid0) begin
         if (exp0.size() == 0) begin
            chk("std_spurious_valid", 32'(rd_valid0), 32'd0);
         end else begin
            last_std = exp0.pop_front();
            chk("std_data", 32'(rd_data0), 32'(last_std));
         end
      end
   end

   // FWFT port: the displayed word is consumed when rd_en meets rd_valid.
   always @(negedge clk) begin
      if (!rst && rd_valid1 && rd_en) begin
         if (exp1.size() == 0) begin
            chk("fwft_spurious_pop", 32'(rd_valid1), 32'd0);
         end else begin
            chk("fwft_data", 32'(rd_data1), 32'(exp1.pop_front()));
         end
      end
   end

   task automatic step(input logic wr, input logic [DW-1:0] din, input logic rd, input logic clr);
      bit was_full, was_empty, wacc, racc;
      int sz;
      wr_en = wr; wr_data = din; rd_en = rd; clr_err = clr;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      wacc = wr && !was_full;
      racc = rd && !was_empty;
      if (racc) begin
         exp0.push_back(model_q[0]);
         exp1.push_back(model_q[0]);
      end
      @(posedge clk);
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(din);
      if (wr && was_full) m_ovf = 1; else if (clr) m_ovf = 0;
      if (rd && was_empty) m_udf = 1; else if (clr) m_udf = 0;
      #1;
      sz = model_q.size();
      chk("count", 32'(count0), 32'(sz));
      chk("count_fwft", 32'(count1), 32'(sz));
      chk("empty", 32'(empty0), 32'(sz == 0));
      chk("full", 32'(full0), 32'(sz == DEPTH));
      chk("almost_full", 32'(af0), 32'(sz >= AF));
      chk("almost_empty", 32'(ae0), 32'(sz <= AE));
      chk("overflow", 32'(ovf0), 32'(m_ovf));
      chk("underflow", 32'(udf0), 32'(m_udf));
      chk("overflow_fwft", 32'(ovf1), 32'(m_ovf));
      chk("std_valid_pulse", 32'(rd_valid0), 32'(racc));
      chk("fwft_valid", 32'(rd_valid1), 32'(sz != 0));
      if (sz != 0) chk("fwft_head", 32'(rd_data1), 32'(model_q[0]));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_count", 32'(count0), 32'd0);
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_full", 32'(full0), 32'd0);
      chk("rst_ae", 32'(ae0), 32'd1);
      chk("rst_af", 32'(af0), 32'd0);
      chk("rst_rd_data", 32'(rd_data0), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid0), 32'd0);
      chk("rst_rd_valid_fwft", 32'(rd_valid1), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);
      chk("rst_udf", 32'(udf0), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill with 0x11..0x88, overflow, then drain in order.
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Underflow: rd_data must hold the last word delivered.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_hold_data", 32'(rd_data0), 32'(last_std));
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Clear and a fresh overflow in the same cycle leave overflow set.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Steady occupancy of 4 with simultaneous read/write across several wraps.
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 4; i < 24; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // FWFT: a word written into the empty FIFO shows up the next cycle unrequested.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("fwft_a5_valid", 32'(rd_valid1), 32'd1);
      chk("fwft_a5_data", 32'(rd_data1), 32'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fwft_after_pop_valid", 32'(rd_valid1), 32'd0);
      chk("fwft_after_pop_empty", 32'(empty1), 32'd1);

      // Reset mid-traffic with five words held and a sticky underflow pending.
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b1, 8'h70, 1'b1, 1'b0);
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count0), 32'd0);
      chk("mid_rst_empty", 32'(empty0), 32'd1);
      chk("mid_rst_full", 32'(full0), 32'd0);
      chk("mid_rst_udf", 32'(udf0), 32'd0);
      chk("mid_rst_ovf", 32'(ovf0), 32'd0);
      chk("mid_rst_rv", 32'(rd_valid0), 32'd0);
      chk("mid_rst_rv_fwft", 32'(rd_valid1), 32'd0);
      chk("mid_rst_count_fwft", 32'(count1), 32'd0);
      model_q.delete(); exp0.delete(); exp1.delete();
      m_ovf = 0; m_udf = 0; last_std = '0;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b1, 8'h3D, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_first_read", 32'(last_std), 32'h3C);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Randomised traffic: fill-biased, drain-biased, then balanced.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 150; i++) begin
            int pw, pr;
            pw = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            pr = (ph == 0) ? 30 : (ph == 1) ? 70 : 50;
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                 $urandom_range(0, 31) == 0);
         end
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("std_queue_drained", 32'(exp0.size()), 32'd0);
      chk("fwft_queue_drained", 32'(exp1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It generalises the team's fixed 8-bit/64-entry buffer to configurable data width and depth. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer/consumer blocks in the same clock domain as the general-purpose rate-decoupling buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 6, log2 of depth; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
AFULL_TH, 56, almost_full asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 8, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request (FWFT: pop/acknowledge of displayed word)
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data holds a valid word (see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync deassert by design): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory is not reset.
- Pointers are ADDR_W+1 bits; the low ADDR_W bits address memory and the MSB is the wrap bit. Pointers wrap naturally modulo 2*DEPTH.
- count = wr_ptr - rd_ptr (modulo 2**(ADDR_W+1)). full = (pointer MSBs differ and low bits equal). empty = (pointers equal).
- All flags and count are decoded from registered pointers. They change only in the cycle after an accepting edge, with no combinational path from wr_en/rd_en.
- Write accept: wr_acc = wr_en & ~full. On accept: mem[wr_ptr] <= wr_data, wr_ptr+1.
- Write to a full FIFO: data dropped, pointers unchanged, overflow <= 1. A read in the same cycle does not rescue the write.
- Read accept: rd_acc = rd_en & ~empty. On accept: rd_ptr+1.
- Read from an empty FIFO: no state change except underflow <= 1. A simultaneous write does not rescue the read.
- Simultaneous wr_acc & rd_acc: both pointers advance, count unchanged. Allowed at every occupancy 1..DEPTH-1.
- Standard mode (FWFT=0): on rd_acc, rd_data <= mem[rd_ptr], registered, so data appears the cycle after the request. rd_valid is a 1-cycle pulse that cycle. With no rd_acc, rd_data holds its last value and rd_valid=0.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr[ADDR_W-1:0]] (combinational read), and rd_valid = ~empty.
  - The head word is visible with no request. rd_en & rd_valid pops it, and the next word is visible the following cycle.
  - A word written into an empty FIFO is visible one cycle after its write edge.
  - rd_data is don't-care while rd_valid=0.
- Error flags: set on the events above and held until clr_err or rst. If clr_err and a new error event occur in the same cycle, set wins (flag = 1).
- Reset mid-operation: all contents logically discarded immediately; count=0 and empty=1 while rst is high.
- Parameter legality (AEMPTY_TH < AFULL_TH, thresholds in range) is checked by an elaboration-time assertion in simulation only.

Test Plan:
- DATA_W=8, ADDR_W=3, FWFT=0: write 0x11..0x88 (8 words) -> full=1, count=8, almost_full=1 (AFULL_TH=6). Then read 8 -> rd_data 0x11..0x88 in order, each one cycle after rd_en with a rd_valid pulse, empty=1 at end.
- Full FIFO: write 0xFF -> dropped, overflow=1, count stays 8. Drain the FIFO -> 0xFF never appears. Pulse clr_err -> overflow=0. Clear plus a new overflow in the same cycle -> overflow stays 1.
- Empty FIFO: rd_en for 1 cycle -> underflow=1, rd_valid=0, rd_data unchanged, count=0.
- Occupancy 4: wr_en & rd_en for 20 cycles with an incrementing pattern -> count constant at 4, pointers wrap at least twice, output sequence matches the input sequence with no loss.
- FWFT=1: write 0xA5 into empty -> next cycle rd_valid=1 and rd_data=0xA5 with no rd_en. Assert rd_en -> following cycle rd_valid=0, empty=1.
- Reset with count=5 and traffic active -> same cycle count=0, empty=1, flags and rd_valid cleared. After release, the first read returns the first post-reset write.
